button_conditioner: RTL and testbench



---
 rtl/button_pkg.sv | 26 ++
 rtl/debounce_bit.sv | 79 +++++++
 rtl/button_conditioner.sv | 68 ++++++
 tb/tb_button_conditioner.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_pkg
// Purpose  : Shared defaults and width helper for the button conditioner.
//            Optional feature macro: BUTTON_FALL_PULSE_EN (used by importers).
// Revision : 1.0 - initial release
// ============================================================================
package button_pkg;

  // Number of conditioned pins on the reference board.
  localparam int c_WIDTH_DEF          = 4;
  // 100 MHz / 62500 = 1.6 kHz sample rate.
  localparam int c_SAMPLE_CNT_MAX_DEF = 62500;
  // 200 samples at 1.6 kHz = 125 ms of stable high before a press counts.
  localparam int c_PULSE_CNT_MAX_DEF  = 200;

  // Bits needed to hold the values 0..max_val; never narrower than one bit,
  // so a degenerate range such as 0..0 still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bit
// Purpose  : One conditioned input: 2-flop synchroniser, tick-driven
//            saturating qualification counter and clean-edge detector.
//            Optional feature macro: BUTTON_FALL_PULSE_EN (adds fall_pulse).
// Revision : 1.0 - initial release
// ============================================================================
module debounce_bit
  import button_pkg::*;
#(
  parameter int PULSE_CNT_MAX = c_PULSE_CNT_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic in,
  output logic clean,
  output logic rise_pulse
`ifdef BUTTON_FALL_PULSE_EN
  ,
  output logic fall_pulse
`endif
);

  localparam int              c_CW       = cnt_width(PULSE_CNT_MAX);
  localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(PULSE_CNT_MAX);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

  logic            r_sync0;
  logic            r_sync1;
  logic [c_CW-1:0] r_cnt;
  logic            r_clean_d;
  logic            w_clean;

  // Bring the asynchronous pin into the clk domain through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= in;
      r_sync1 <= r_sync0;
    end
  end

  // Count consecutive high samples on each tick; any low sample restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (tick) begin
      if (!r_sync1) begin
        r_cnt <= '0;
      end else if (r_cnt != c_CNT_FULL) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
    end
  end

  // Clean level is a decode of the registered counter, so it cannot glitch.
  assign w_clean = (r_cnt == c_CNT_FULL);

  // Delay the clean level by one cycle for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clean_d <= 1'b0;
    end else begin
      r_clean_d <= w_clean;
    end
  end

  assign clean      = w_clean;
  assign rise_pulse = w_clean & ~r_clean_d;
`ifdef BUTTON_FALL_PULSE_EN
  assign fall_pulse = ~w_clean & r_clean_d;
`endif

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronises, debounces and edge-detects WIDTH raw button or
//            switch pins using one shared sample timer.
//            Optional feature macro: BUTTON_FALL_PULSE_EN (adds fall_pulse).
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner
  import button_pkg::*;
#(
  parameter int WIDTH          = c_WIDTH_DEF,
  parameter int SAMPLE_CNT_MAX = c_SAMPLE_CNT_MAX_DEF,
  parameter int PULSE_CNT_MAX  = c_PULSE_CNT_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise_pulse
`ifdef BUTTON_FALL_PULSE_EN
  ,
  output logic [WIDTH-1:0] fall_pulse
`endif
);

  // Timer only needs to reach SAMPLE_CNT_MAX-1; with SAMPLE_CNT_MAX=1 it
  // sits at zero and tick is permanently high.
  localparam int              c_TW         = cnt_width(SAMPLE_CNT_MAX - 1);
  localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(SAMPLE_CNT_MAX - 1);
  localparam logic [c_TW-1:0] c_TIMER_ONE  = c_TW'(1);

  logic [c_TW-1:0] r_timer;
  logic            w_tick;

  assign w_tick = (r_timer == c_TIMER_LAST);

  // Shared sample timer: counts 0..SAMPLE_CNT_MAX-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + c_TIMER_ONE;
    end
  end

  // One independent conditioner per pin, all sampling on the same tick.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .PULSE_CNT_MAX (PULSE_CNT_MAX)
    ) u_debounce_bit (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (w_tick),
      .in         (in[gi]),
      .clean      (clean[gi]),
      .rise_pulse (rise_pulse[gi])
`ifdef BUTTON_FALL_PULSE_EN
      ,
      .fall_pulse (fall_pulse[gi])
`endif
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Self-checking bench for button_conditioner. Two instances share
//            stimulus: A (SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3) and
//            B (SAMPLE_CNT_MAX=1, PULSE_CNT_MAX=1). A cycle model predicts
//            outputs into a scoreboard queue; table phases and hand-written
//            sequences add checks on latency windows and pulse counts.
//            Optional feature macro: BUTTON_FALL_PULSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int W  = 4;
  localparam int SA = 4;
  localparam int PA = 3;
  localparam int SB = 1;
  localparam int PB = 1;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic [W-1:0] in_pins = '0;
  logic [W-1:0] clean_a, rise_a, clean_b, rise_b;
`ifdef BUTTON_FALL_PULSE_EN
  logic [W-1:0] fall_a, fall_b;
`endif

  always #5 clk = ~clk;

  button_conditioner #(.WIDTH(W), .SAMPLE_CNT_MAX(SA), .PULSE_CNT_MAX(PA)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in_pins),
    .clean      (clean_a),
    .rise_pulse (rise_a)
`ifdef BUTTON_FALL_PULSE_EN
    ,
    .fall_pulse (fall_a)
`endif
  );

  button_conditioner #(.WIDTH(W), .SAMPLE_CNT_MAX(SB), .PULSE_CNT_MAX(PB)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in_pins),
    .clean      (clean_b),
    .rise_pulse (rise_b)
`ifdef BUTTON_FALL_PULSE_EN
    ,
    .fall_pulse (fall_b)
`endif
  );

  // ---------------- scoreboard / model ----------------
  typedef struct packed {
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } pair_t;

  pair_t        sb_q[$];
  logic [W-1:0] hist[$];   // pin values at the last three edges since reset
  int           k_edge;    // edges since reset release
  int           run[2][W]; // consecutive high tick samples per instance/bit
  logic [W-1:0] prev[2];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got < lo || got > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d at t=%0t", name, got, lo, hi, $time);
    end
  endtask

  // Predict one instance: a pressed level means the last P tick samples of
  // the pin, as seen two edges late, were all high.
  task automatic model_one(input int d, input int p, input logic is_tick,
                           input logic [W-1:0] sample, output exp_t e);
    logic [W-1:0] c;
    for (int i = 0; i < W; i++) begin
      if (is_tick) run[d][i] = sample[i] ? run[d][i] + 1 : 0;
      c[i] = (run[d][i] >= p);
    end
    e.clean = c;
    e.rise  = c & ~prev[d];
    e.fall  = ~c & prev[d];
    prev[d] = c;
  endtask

  task automatic model_edge();
    pair_t        p;
    logic [W-1:0] sample;
    if (!rst_n) begin
      k_edge = 0;
      hist.delete();
      for (int d = 0; d < 2; d++) begin
        prev[d] = '0;
        for (int i = 0; i < W; i++) run[d][i] = 0;
      end
      p.a = '0;
      p.b = '0;
    end else begin
      k_edge++;
      hist.push_back(in_pins);
      if (hist.size() > 3) void'(hist.pop_front());
      sample = (hist.size() == 3) ? hist[0] : '0;
      model_one(0, PA, (k_edge % SA) == 0, sample, p.a);
      model_one(1, PB, (k_edge % SB) == 0, sample, p.b);
    end
    sb_q.push_back(p);
  endtask

  // One clock: predict at the edge, compare on the falling edge.
  task automatic cyc();
    pair_t p;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    p = sb_q.pop_front();
    check("clean_a", clean_a, p.a.clean);
    check("rise_a",  rise_a,  p.a.rise);
    check("clean_b", clean_b, p.b.clean);
    check("rise_b",  rise_b,  p.b.rise);
`ifdef BUTTON_FALL_PULSE_EN
    check("fall_a",  fall_a,  p.a.fall);
    check("fall_b",  fall_b,  p.b.fall);
`endif
  endtask

  task automatic do_reset(input logic [W-1:0] v);
    rst_n   = 1'b0;
    in_pins = v;
    repeat (3) cyc();
    check("reset_clean", clean_a | clean_b, 0);
    check("reset_rise",  rise_a | rise_b, 0);
    rst_n = 1'b1;
  endtask

  // ---------------- table phases ----------------
  typedef struct {
    logic         rst_n;
    logic [W-1:0] in;
    int           cycles;
    logic [W-1:0] exp_clean;  // instance A clean at end of phase
  } phase_t;

  phase_t tbl[9];

  initial begin
    int n, cnt, fcnt, found;
    logic [W-1:0] seen;

    tbl[0] = '{1'b0, 4'hF,  5, 4'h0};
    tbl[1] = '{1'b1, 4'hF, 10, 4'h0};
    tbl[2] = '{1'b1, 4'hF,  2, 4'hF};
    tbl[3] = '{1'b1, 4'hF, 20, 4'hF};
    tbl[4] = '{1'b1, 4'h0,  1, 4'hF};
    tbl[5] = '{1'b1, 4'h0,  4, 4'h0};
    tbl[6] = '{1'b1, 4'h5, 16, 4'h5};
    tbl[7] = '{1'b1, 4'hA, 12, 4'hA};
    tbl[8] = '{1'b0, 4'hA,  2, 4'h0};

    for (int t = 0; t < 9; t++) begin
      rst_n   = tbl[t].rst_n;
      in_pins = tbl[t].in;
      repeat (tbl[t].cycles) cyc();
      check($sformatf("phase%0d_clean", t), clean_a, tbl[t].exp_clean);
    end

    // Clean press on bit 0, then long hold: one pulse only.
    do_reset('0);
    repeat (5) cyc();
    in_pins[0] = 1'b1;
    n = 0; found = 0;
    while (n < 30 && !found) begin
      cyc(); n++;
      if (clean_a[0]) begin
        found = 1;
        check("press_rise_coincident", rise_a[0], 1);
      end
    end
    check_range("press_latency", n, 11, 15);
    cnt = 0;
    repeat (100) begin cyc(); if (rise_a[0]) cnt++; end
    check("press_hold_no_repeat", cnt, 0);

    // Bounce on bit 1: no pulse while toggling, one after it settles.
    do_reset('0);
    repeat (3) cyc();
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      in_pins[1] = ((c / 3) % 2) == 0;
      cyc();
      if (rise_a[1]) cnt++;
    end
    check("bounce_no_pulse", cnt, 0);
    in_pins[1] = 1'b1;
    cnt = 0;
    repeat (40) begin cyc(); if (rise_a[1]) cnt++; end
    check("bounce_single_pulse", cnt, 1);

    // Release on bit 2.
    do_reset('0);
    in_pins[2] = 1'b1;
    n = 0;
    while (n < 30 && !clean_a[2]) begin cyc(); n++; end
    check("release_pre_clean", clean_a[2], 1);
    repeat (2) cyc();
    in_pins[2] = 1'b0;
    n = 0; found = 0; cnt = 0; fcnt = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (!found && !clean_a[2]) begin found = 1; n = c; end
      if (rise_a[2]) cnt++;
`ifdef BUTTON_FALL_PULSE_EN
      if (fall_a[2]) fcnt++;
`endif
    end
    check_range("release_latency", n, 1, 6);
    check("release_no_rise", cnt, 0);
`ifdef BUTTON_FALL_PULSE_EN
    check("release_fall_once", fcnt, 1);
`endif

    // Simultaneous press with a reset pulse in the middle.
    do_reset('0);
    in_pins = 4'hF;
    seen = '0;
    repeat (8) begin cyc(); seen |= clean_a; end
    rst_n = 1'b0;
    repeat (2) begin cyc(); seen |= clean_a | rise_a; end
    rst_n = 1'b1;
    check("midreset_no_clean", seen, 0);
    n = 0; found = 0;
    while (n < 30 && !found) begin
      cyc(); n++;
      if (rise_a != '0) begin
        found = 1;
        check("simul_rise_all", rise_a, 4'hF);
      end
    end
    check_range("simul_requalify", n, 11, 15);

    // Minimal configuration: clean rises 3 cycles after the pin.
    do_reset('0);
    repeat (2) cyc();
    in_pins = 4'h8;
    n = 0;
    while (n < 10 && !clean_b[3]) begin cyc(); n++; end
    check("min_cfg_latency", n, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
